// File: rtl/nios_cpu_debug_scan_master.sv
// -----------------------------------------------------------------------------
// nios_cpu_debug_scan_master
//
// Host-side driver for the Nios II debug slave virtual-JTAG port. A command
// (2-bit IR + DR_LEN-bit payload) accepted on cmd_valid/cmd_ready is turned
// into one virtual-JTAG scan: UIR -> CDR -> SDR (DR_LEN bits) -> UDR -> RTI.
// Every non-idle state lasts whole tck periods of 2*TCK_HALF clk cycles.
// Each period has a low half followed by a high half. The slave's
// vji_ir_out and vji_tdo are captured into rsp_ir / rsp_data. rsp_valid
// pulses for one cycle when the block returns to idle.
//
// Optional feature (compile-time macro NIOS_SCAN_IR_CACHE_EN):
//   The block remembers the IR of the last completed scan. If a new command
//   carries the same IR, the UIR period is skipped.
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   cmd_valid/cmd_ready     command handshake (ready == idle)
//   cmd_ir, cmd_data        IR value and DR payload (shifted LSB first)
//   rsp_valid               one-cycle response strobe
//   rsp_data                captured tdo bits, first bit shifted in bit 0
//   rsp_ir                  vji_ir_out sampled on the CDR tck rising edge
//   vji_tck, vji_tdi        generated scan clock and serial data out
//   vji_tdo, vji_ir_out     serial data and status IR from the slave
//   vji_ir_in               IR presented to the slave
//   vji_uir .. vji_rti      virtual state indicators
// -----------------------------------------------------------------------------
module nios_cpu_debug_scan_master #(
    parameter int DR_LEN   = 38,
    parameter int TCK_HALF = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_ir,
    input  logic [DR_LEN-1:0] cmd_data,
    output logic              rsp_valid,
    output logic [DR_LEN-1:0] rsp_data,
    output logic [1:0]        rsp_ir,
    output logic              vji_tck,
    output logic              vji_tdi,
    input  logic              vji_tdo,
    output logic [1:0]        vji_ir_in,
    input  logic [1:0]        vji_ir_out,
    output logic              vji_uir,
    output logic              vji_cdr,
    output logic              vji_sdr,
    output logic              vji_udr,
    output logic              vji_rti
);

    localparam int P  = 2 * TCK_HALF;
    localparam int PW = $clog2(P);
    localparam int BW = $clog2(DR_LEN);

    // Phase within a tck period: 0..TCK_HALF-1 is the low half, the rest is high.
    localparam logic [PW-1:0] PH_RISE  = PW'(TCK_HALF - 1);  // last low cycle: tck rises at its end
    localparam logic [PW-1:0] PH_HIGH  = PW'(TCK_HALF);
    localparam logic [PW-1:0] PH_LAST  = PW'(P - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DR_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_UIR,
        S_CDR,
        S_SDR,
        S_UDR,
        S_RTI
    } state_t;

    state_t            state_q,     state_d;
    logic [PW-1:0]     phase_q,     phase_d;
    logic [BW-1:0]     bit_cnt_q,   bit_cnt_d;
    logic [DR_LEN-1:0] sh_q,        sh_d;
    logic              tdo_smp_q,   tdo_smp_d;
    logic [1:0]        ir_in_q,     ir_in_d;
    logic [DR_LEN-1:0] rsp_data_q,  rsp_data_d;
    logic [1:0]        rsp_ir_q,    rsp_ir_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rti_seen_q,  rti_seen_d;

    logic busy;
    logic tck_rise;     // this clk edge is the one where tck goes 0 -> 1
    logic period_end;   // this clk edge closes the current tck period
    logic skip_uir;

    assign busy       = (state_q != S_IDLE);
    assign tck_rise   = busy && (phase_q == PH_RISE);
    assign period_end = busy && (phase_q == PH_LAST);

`ifdef NIOS_SCAN_IR_CACHE_EN
    logic [1:0] last_ir_q,  last_ir_d;
    logic       ir_vld_q,   ir_vld_d;

    // Update on the edge that leaves RTI, so a command accepted in the
    // rsp_valid cycle already compares against the scan just finished.
    always_comb begin
        last_ir_d = last_ir_q;
        ir_vld_d  = ir_vld_q;
        if (state_q == S_RTI && period_end) begin
            last_ir_d = ir_in_q;
            ir_vld_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_ir_q <= 2'b00;
            ir_vld_q  <= 1'b0;
        end else begin
            last_ir_q <= last_ir_d;
            ir_vld_q  <= ir_vld_d;
        end
    end

    assign skip_uir = ir_vld_q && (cmd_ir == last_ir_q);
`else
    assign skip_uir = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        bit_cnt_d   = bit_cnt_q;
        sh_d        = sh_q;
        tdo_smp_d   = tdo_smp_q;
        ir_in_d     = ir_in_q;
        rsp_data_d  = rsp_data_q;
        rsp_ir_d    = rsp_ir_q;
        rsp_valid_d = 1'b0;
        rti_seen_d  = rti_seen_q;

        if (busy) begin
            phase_d = period_end ? '0 : phase_q + PW'(1);
        end else begin
            phase_d = '0;
        end

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    ir_in_d   = cmd_ir;
                    sh_d      = cmd_data;
                    bit_cnt_d = '0;
                    state_d   = skip_uir ? S_CDR : S_UIR;
                end
            end
            S_UIR: begin
                if (period_end) begin
                    state_d = S_CDR;
                end
            end
            S_CDR: begin
                if (tck_rise) begin
                    rsp_ir_d = vji_ir_out;
                end
                if (period_end) begin
                    state_d = S_SDR;
                end
            end
            S_SDR: begin
                if (tck_rise) begin
                    tdo_smp_d = vji_tdo;
                end
                // tdo_smp_q was captured earlier in this period.
                if (period_end) begin
                    sh_d = {tdo_smp_q, sh_q[DR_LEN-1:1]};
                    if (bit_cnt_q == BIT_LAST) begin
                        state_d = S_UDR;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end
                end
            end
            S_UDR: begin
                if (period_end) begin
                    rsp_data_d = sh_q;
                    state_d    = S_RTI;
                end
            end
            S_RTI: begin
                if (period_end) begin
                    rsp_valid_d = 1'b1;
                    rti_seen_d  = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            phase_q     <= '0;
            bit_cnt_q   <= '0;
            sh_q        <= '0;
            tdo_smp_q   <= 1'b0;
            ir_in_q     <= 2'b00;
            rsp_data_q  <= '0;
            rsp_ir_q    <= 2'b00;
            rsp_valid_q <= 1'b0;
            rti_seen_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            bit_cnt_q   <= bit_cnt_d;
            sh_q        <= sh_d;
            tdo_smp_q   <= tdo_smp_d;
            ir_in_q     <= ir_in_d;
            rsp_data_q  <= rsp_data_d;
            rsp_ir_q    <= rsp_ir_d;
            rsp_valid_q <= rsp_valid_d;
            rti_seen_q  <= rti_seen_d;
        end
    end

    // All outputs decode directly from flops, so an asynchronous reset
    // returns them to their idle values immediately.
    assign cmd_ready = !busy;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_ir    = rsp_ir_q;
    assign vji_tck   = busy && (phase_q >= PH_HIGH);
    assign vji_tdi   = (state_q == S_SDR) && sh_q[0];
    assign vji_ir_in = ir_in_q;
    assign vji_uir   = (state_q == S_UIR);
    assign vji_cdr   = (state_q == S_CDR);
    assign vji_sdr   = (state_q == S_SDR);
    assign vji_udr   = (state_q == S_UDR);
    assign vji_rti   = (state_q == S_RTI) || (!busy && rti_seen_q);

endmodule
